// File: rtl/y86_fetch.sv
// y86_fetch: byte-serial Y86 instruction fetch unit.
// A start in IDLE captures pc and reads the instruction one byte at a time
// from a request/acknowledge memory port. Bytes are decoded into icode/ifun,
// the optional register byte (rA/rB) and the optional little-endian
// 32-bit constant (valC).
//
// Ports:
//   clock, reset            rising-edge clock; asynchronous active-high reset
//   start, pc               fetch request and instruction byte address
//   mem_req, mem_addr       byte-read request and its address (pc + byte index)
//   mem_ack, mem_rdata      read completion and read data
//   icode, ifun, rA, rB     decoded instruction fields
//   valC                    decoded constant
//   need_regids, need_valC  length flags for the PC-increment stage
//   instr_valid             one-cycle pulse, all decode outputs complete
//   halt, imem_error        sticky status; either one parks the unit in STOP
//   busy                    high whenever the unit is not IDLE
module y86_fetch #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [31:0] valC,
  output logic        need_regids,
  output logic        need_valC,
  output logic        instr_valid,
  output logic        halt,
  output logic        imem_error,
  output logic        busy
);

  // The wait counter only has to hold 0..TIMEOUT-1: the cycle that would
  // reach TIMEOUT aborts the fetch instead of incrementing.
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [NIB_W-1:0]  REG_NONE  = 4'hF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BYTE0 = 3'd1,
    REGS  = 3'd2,
    CONST = 3'd3,
    DONE  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t             state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [1:0]         const_cnt;

  logic               xfer_c;
  logic               timeout_c;
  logic [NIB_W-1:0]   rd_icode_c;
  logic               rd_regids_c;
  logic               rd_valc_c;
  logic               rd_bad_c;

  // A transfer completes on a requested, acknowledged edge; an ack with no
  // request outstanding is ignored by construction.
  assign xfer_c     = mem_req & mem_ack;
  assign timeout_c  = mem_req & ~mem_ack & (wait_cnt == WAIT_LAST);
  assign rd_icode_c = mem_rdata[7:4];

  // Length decode of the byte currently on mem_rdata (used at BYTE0 only).
  always_comb begin
    rd_regids_c = 1'b0;
    rd_valc_c   = 1'b0;
    rd_bad_c    = 1'b0;
    case (rd_icode_c)
      4'h2, 4'h6, 4'hA, 4'hB: rd_regids_c = 1'b1;
      4'h3, 4'h4, 4'h5: begin
        rd_regids_c = 1'b1;
        rd_valc_c   = 1'b1;
      end
      4'h7, 4'h8:             rd_valc_c   = 1'b1;
      4'hC, 4'hD, 4'hE, 4'hF: rd_bad_c    = 1'b1;
      default: ;
    endcase
  end

  // Consecutive unacknowledged request cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!mem_req || mem_ack || timeout_c) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Fetch sequencer with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      const_cnt   <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      icode       <= '0;
      ifun        <= '0;
      rA          <= REG_NONE;
      rB          <= REG_NONE;
      valC        <= '0;
      need_regids <= 1'b0;
      need_valC   <= 1'b0;
      instr_valid <= 1'b0;
      halt        <= 1'b0;
      imem_error  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !halt && !imem_error) begin
            state     <= BYTE0;
            mem_req   <= 1'b1;
            mem_addr  <= pc;
            busy      <= 1'b1;
            rA        <= REG_NONE;
            rB        <= REG_NONE;
            valC      <= '0;
            const_cnt <= '0;
          end
        end

        BYTE0: begin
          if (xfer_c) begin
            icode       <= rd_icode_c;
            ifun        <= mem_rdata[3:0];
            mem_addr    <= mem_addr + ADDR_W'(1);
            need_regids <= rd_regids_c;
            need_valC   <= rd_valc_c;
            if (rd_bad_c) begin
              imem_error <= 1'b1;
            end
            if (rd_icode_c == 4'h0) begin
              halt <= 1'b1;
            end
            if (rd_regids_c) begin
              state <= REGS;
            end else if (rd_valc_c) begin
              state <= CONST;
            end else begin
              state       <= DONE;
              mem_req     <= 1'b0;
              instr_valid <= 1'b1;
            end
          end else if (timeout_c) begin
            imem_error  <= 1'b1;
            state       <= DONE;
            mem_req     <= 1'b0;
            instr_valid <= 1'b1;
          end
        end

        REGS: begin
          if (xfer_c) begin
            rA       <= mem_rdata[7:4];
            rB       <= mem_rdata[3:0];
            mem_addr <= mem_addr + ADDR_W'(1);
            if (need_valC) begin
              state <= CONST;
            end else begin
              state       <= DONE;
              mem_req     <= 1'b0;
              instr_valid <= 1'b1;
            end
          end else if (timeout_c) begin
            imem_error  <= 1'b1;
            state       <= DONE;
            mem_req     <= 1'b0;
            instr_valid <= 1'b1;
          end
        end

        CONST: begin
          if (xfer_c) begin
            // Little-endian: byte n of the constant lands in valC[8n+7:8n].
            case (const_cnt)
              2'd0:    valC[7:0]   <= mem_rdata;
              2'd1:    valC[15:8]  <= mem_rdata;
              2'd2:    valC[23:16] <= mem_rdata;
              default: valC[31:24] <= mem_rdata;
            endcase
            mem_addr <= mem_addr + ADDR_W'(1);
            if (const_cnt == 2'd3) begin
              state       <= DONE;
              mem_req     <= 1'b0;
              instr_valid <= 1'b1;
            end else begin
              const_cnt <= const_cnt + 2'd1;
            end
          end else if (timeout_c) begin
            imem_error  <= 1'b1;
            state       <= DONE;
            mem_req     <= 1'b0;
            instr_valid <= 1'b1;
          end
        end

        // instr_valid was raised on entry; it drops here after one cycle.
        DONE: begin
          if (halt || imem_error) begin
            state <= STOP;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        // Parked until reset.
        STOP: state <= STOP;

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y86_fetch.sv
// tb_y86_fetch: directed and randomized checks of y86_fetch against a
// byte-image memory and an instruction-level expectation model.
module tb_y86_fetch;

  localparam int unsigned TO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [31:0] valC;
  logic        need_regids;
  logic        need_valC;
  logic        instr_valid;
  logic        halt;
  logic        imem_error;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [64];
  int          ack_wait  = 0;
  bit          ack_never = 1'b0;
  bit          noise     = 1'b0;
  int          wcnt      = 0;
  logic [31:0] addr_q [$];

  y86_fetch #(.TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .pc          (pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .icode       (icode),
    .ifun        (ifun),
    .rA          (rA),
    .rB          (rB),
    .valC        (valC),
    .need_regids (need_regids),
    .need_valC   (need_valC),
    .instr_valid (instr_valid),
    .halt        (halt),
    .imem_error  (imem_error),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd(input logic [31:0] a);
    return mem[a[5:0]];
  endfunction

  task automatic load(input logic [31:0] a, input logic [7:0] b);
    mem[a[5:0]] = b;
  endtask

  // Memory responder: ack after ack_wait idle cycles per byte; random ack
  // noise while no request is outstanding.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clock);
      mem_rdata = mem[mem_addr[5:0]];
      if (mem_req && !reset) begin
        if (ack_never || wcnt < ack_wait) begin
          mem_ack = 1'b0;
          wcnt++;
        end else begin
          mem_ack = 1'b1;
          wcnt = 0;
          addr_q.push_back(mem_addr);
        end
      end else begin
        wcnt    = 0;
        mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  task automatic chk_reset_values();
    chk("rst_icode",   32'(icode),       32'h0);
    chk("rst_ifun",    32'(ifun),        32'h0);
    chk("rst_rA",      32'(rA),          32'hF);
    chk("rst_rB",      32'(rB),          32'hF);
    chk("rst_valC",    valC,             32'h0);
    chk("rst_addr",    mem_addr,         32'h0);
    chk("rst_nregs",   32'(need_regids), 32'h0);
    chk("rst_nvalc",   32'(need_valC),   32'h0);
    chk("rst_req",     32'(mem_req),     32'h0);
    chk("rst_valid",   32'(instr_valid), 32'h0);
    chk("rst_halt",    32'(halt),        32'h0);
    chk("rst_err",     32'(imem_error),  32'h0);
    chk("rst_busy",    32'(busy),        32'h0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    #1;
    chk_reset_values();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    addr_q.delete();
  endtask

  // Fetch one instruction from the current memory image and check every
  // decode output, the address sequence, latency and the one-cycle pulse.
  task automatic fetch(input string tag, input logic [31:0] fpc, input int w);
    logic [7:0]  b0, b1;
    logic [3:0]  ic, e_ra, e_rb;
    logic        bad, nr, nv, got, prev_req;
    logic [31:0] e_valc, off, prev_addr;
    int          len, n;

    b0  = rd(fpc);
    ic  = b0[7:4];
    bad = (ic > 4'hB);
    nr  = !bad && (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
    nv  = !bad && (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8});
    len = 1 + (nr ? 1 : 0) + (nv ? 4 : 0);
    b1  = rd(fpc + 32'd1);
    e_ra = nr ? b1[7:4] : 4'hF;
    e_rb = nr ? b1[3:0] : 4'hF;
    off  = nr ? 32'd2 : 32'd1;
    e_valc = nv ? {rd(fpc + off + 32'd3), rd(fpc + off + 32'd2),
                   rd(fpc + off + 32'd1), rd(fpc + off)} : 32'h0;

    addr_q.delete();
    ack_wait = w;
    @(negedge clock);
    pc    = fpc;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk({tag, "_busy"},   32'(busy),    32'h1);
    chk({tag, "_req"},    32'(mem_req), 32'h1);
    chk({tag, "_addr0"},  mem_addr,     fpc);
    chk({tag, "_preA"},   32'(rA),      32'hF);
    chk({tag, "_preC"},   valC,         32'h0);

    n = 0;
    got = 1'b0;
    prev_req  = 1'b1;
    prev_addr = fpc;
    while (n < 200 && !got) begin
      @(posedge clock);
      #1;
      n++;
      if (prev_req && !mem_ack && mem_req)
        chk({tag, "_addr_stable"}, mem_addr, prev_addr);
      prev_req  = mem_req;
      prev_addr = mem_addr;
      if (instr_valid) got = 1'b1;
    end
    chk({tag, "_latency"}, 32'(n),           32'(len * (w + 1)));
    chk({tag, "_icode"},   32'(icode),       32'(ic));
    chk({tag, "_ifun"},    32'(ifun),        32'(b0[3:0]));
    chk({tag, "_rA"},      32'(rA),          32'(e_ra));
    chk({tag, "_rB"},      32'(rB),          32'(e_rb));
    chk({tag, "_valC"},    valC,             e_valc);
    chk({tag, "_nregs"},   32'(need_regids), 32'(nr));
    chk({tag, "_nvalc"},   32'(need_valC),   32'(nv));
    chk({tag, "_halt"},    32'(halt),        32'(ic == 4'h0));
    chk({tag, "_err"},     32'(imem_error),  32'(bad));
    chk({tag, "_nxfer"},   32'(addr_q.size()), 32'(len));
    for (int k = 0; k < len; k++) begin
      if (k < addr_q.size())
        chk({tag, "_xaddr"}, addr_q[k], fpc + 32'(k));
    end

    @(posedge clock);
    #1;
    chk({tag, "_pulse1"},  32'(instr_valid), 32'h0);
    chk({tag, "_busy2"},   32'(busy),        32'((ic == 4'h0) || bad));
    chk({tag, "_holdA"},   32'(rA),          32'(e_ra));
    chk({tag, "_holdC"},   valC,             e_valc);
  endtask

  // Start must be ignored once parked in STOP.
  task automatic chk_stopped(input string tag);
    @(negedge clock);
    pc    = 32'h0;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      chk({tag, "_noreq"}, 32'(mem_req), 32'h0);
      chk({tag, "_busy"},  32'(busy),    32'h1);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] fpc;
    logic [3:0]  ic;
    int          n;

    reset = 1'b1;
    start = 1'b0;
    pc    = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    chk_reset_values();
    @(negedge clock);
    reset = 1'b0;

    // irmovl $0x12345678, %ebx
    load(32'h100, 8'h30); load(32'h101, 8'hF3); load(32'h102, 8'h78);
    load(32'h103, 8'h56); load(32'h104, 8'h34); load(32'h105, 8'h12);
    fetch("irmovl", 32'h100, 0);

    // nop at the top of memory, then a call straddling the wrap
    load(32'hFFFFFFFF, 8'h10);
    fetch("nop_wrap", 32'hFFFFFFFF, 0);
    load(32'hFFFFFFFE, 8'h80); load(32'hFFFFFFFF, 8'h11); load(32'h0, 8'h22);
    load(32'h1, 8'h33); load(32'h2, 8'h44);
    fetch("call_wrap", 32'hFFFFFFFE, 0);

    // rrmovl with three wait cycles per byte
    load(32'h600, 8'h20); load(32'h601, 8'h12);
    fetch("rrmovl_wait", 32'h600, 3);

    // random valid instructions, random waits, ack noise while idle
    noise = 1'b1;
    for (int i = 0; i < 30; i++) begin
      fpc = $urandom;
      if (i % 5 == 0) fpc = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
      for (int k = 0; k < 6; k++) load(fpc + 32'(k), 8'($urandom));
      ic = 4'($urandom_range(1, 11));
      load(fpc, {ic, 4'($urandom)});
      fetch("rand", fpc, $urandom_range(0, 3));
    end
    noise = 1'b0;

    // halt parks the unit
    load(32'h2000, 8'h00);
    fetch("halt", 32'h2000, 0);
    chk_stopped("halt_stop");
    chk("halt_sticky", 32'(halt), 32'h1);
    do_reset();

    // invalid icode
    load(32'h3000, 8'hE0);
    fetch("bad_icode", 32'h3000, 1);
    chk_stopped("bad_stop");
    do_reset();

    // memory never acknowledges: abort after TO wait cycles
    ack_never = 1'b1;
    @(negedge clock);
    pc    = 32'h4000;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    n = 0;
    while (n < 100 && !imem_error) begin
      @(posedge clock);
      #1;
      n++;
      if (!imem_error) chk("to_addr_stable", mem_addr, 32'h4000);
    end
    chk("to_cycles", 32'(n),           32'(TO));
    chk("to_valid",  32'(instr_valid), 32'h1);
    chk("to_req",    32'(mem_req),     32'h0);
    ack_never = 1'b0;
    do_reset();

    // reset while collecting the constant of an irmovl
    load(32'h500, 8'h30); load(32'h501, 8'hF5); load(32'h502, 8'hEF);
    load(32'h503, 8'hBE); load(32'h504, 8'hAD); load(32'h505, 8'hDE);
    ack_wait = 0;
    @(negedge clock);
    pc    = 32'h500;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("mid_req_before", 32'(mem_req), 32'h1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_req_async", 32'(mem_req),     32'h0);
    chk("mid_valid",     32'(instr_valid), 32'h0);
    chk("mid_busy",      32'(busy),        32'h0);
    @(posedge clock);
    #1;
    chk("mid_valid2",    32'(instr_valid), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    fetch("after_reset", 32'h500, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
